// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline control: register width, forwarding
// source encodings, hazard FSM states and the shadow-stage records.
package core_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;
  localparam logic [1:0] FWD_WBH     = 2'b11;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_LDSTALL = 2'd1,
    HZ_FLUSH   = 2'd2
  } hz_state_e;

  // Only the EX entry needs the load flag; older entries just track the writer.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } shadow_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
  } stage_t;

  // hit[0]=EX, hit[1]=MEM, hit[2]=WB; youngest usable producer wins.
  function automatic logic [1:0] fwd_pick(input logic [2:0] hit, input logic ex_ld);
    if (hit[0] && !ex_ld) return FWD_MEM;
    else if (hit[1])      return FWD_WB;
    else if (hit[2])      return FWD_WBH;
    else                  return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/hz_shadow_pipe.sv
// Shadow copy of the EX->MEM->WB destination registers, advanced every cycle,
// with per-stage source-operand match flags for the ID instruction.
module hz_shadow_pipe
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_v,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_ld,
  input  logic              rs1_v,
  input  logic [REG_AW-1:0] rs1,
  input  logic              rs2_v,
  input  logic [REG_AW-1:0] rs2,
  output logic [2:0]        hit1,
  output logic [2:0]        hit2,
  output logic              ex_ld
);

  shadow_t ex_q;
  stage_t  mem_q;
  stage_t  wb_q;

  function automatic logic match(input logic rv, input logic [REG_AW-1:0] rs,
                                 input logic sv, input logic [REG_AW-1:0] srd);
    return rv && (rs != '0) && sv && (srd == rs);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= '{v: in_v, rd: in_rd, ld: in_ld};
      mem_q <= '{v: ex_q.v, rd: ex_q.rd};
      wb_q  <= mem_q;
    end
  end

  always_comb begin
    hit1  = {match(rs1_v, rs1, wb_q.v, wb_q.rd),
             match(rs1_v, rs1, mem_q.v, mem_q.rd),
             match(rs1_v, rs1, ex_q.v, ex_q.rd)};
    hit2  = {match(rs2_v, rs2, wb_q.v, wb_q.rd),
             match(rs2_v, rs2, mem_q.v, mem_q.rd),
             match(rs2_v, rs2, ex_q.v, ex_q.rd)};
    ex_ld = ex_q.ld;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush sequencing,
// registered EX operand forwarding selects and stall/flush perf counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW       = core_pkg::REG_AW,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_rs1_v,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs2_v,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rd_v,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       hit1, hit2;
  logic             ex_ld;
  logic             ld_hazard;
  logic             stall;
  logic             flush;
  logic             ex_in_v;
  logic [1:0]       fwd1_q, fwd2_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  hz_shadow_pipe u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .in_v  (ex_in_v),
    .in_rd (id_rd),
    .in_ld (id_is_load),
    .rs1_v (id_rs1_v),
    .rs1   (id_rs1),
    .rs2_v (id_rs2_v),
    .rs2   (id_rs2),
    .hit1  (hit1),
    .hit2  (hit2),
    .ex_ld (ex_ld)
  );

  // Outputs are gated by rst_n so reset forces every control line low at once.
  always_comb begin
    ld_hazard = id_valid & (hit1[0] | hit2[0]) & ex_ld;
    stall     = rst_n & ld_hazard & ~ex_redirect & (state_q != HZ_FLUSH);
    flush     = rst_n & (ex_redirect | (state_q == HZ_FLUSH));
    ex_in_v   = id_valid & id_rd_v & (id_rd != '0) & ~stall & ~flush;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HZ_RUN: begin
        if (ex_redirect) begin
          state_d = HZ_FLUSH;
          cnt_d   = FLUSH_INIT;
        end else if (ld_hazard) begin
          state_d = HZ_LDSTALL;
        end
      end
      HZ_LDSTALL: begin
        if (ex_redirect) begin
          state_d = HZ_FLUSH;
          cnt_d   = FLUSH_INIT;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_FLUSH: begin
        if (ex_redirect)      cnt_d   = FLUSH_INIT;
        else if (cnt_q == '0) state_d = HZ_RUN;
        else                  cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      cnt_q       <= '0;
      fwd1_q      <= FWD_REGFILE;
      fwd2_q      <= FWD_REGFILE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd1_q  <= (stall | flush) ? FWD_REGFILE : fwd_pick(hit1, ex_ld);
      fwd2_q  <= (stall | flush) ? FWD_REGFILE : fwd_pick(hit2, ex_ld);
      if (stall)       stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ex_redirect) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall | flush;
  assign flush_id  = flush;
  assign fwd_sel1  = fwd1_q;
  assign fwd_sel2  = fwd2_q;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, reset-during-stall sequence and
// randomized traffic against an instruction-history reference model.
module tb_hazard_ctrl;

  localparam int FC = 2;
  localparam int CW = 32;
  localparam int NV = 17;

  typedef struct {
    logic        valid;
    logic        r1v;
    logic [4:0]  r1;
    logic        r2v;
    logic [4:0]  r2;
    logic        rdv;
    logic [4:0]  rd;
    logic        ld;
    logic        redir;
    logic        e_stall;
    logic        e_flush;
    logic [1:0]  e_state;
    logic [1:0]  e_fwd1;
    logic [1:0]  e_fwd2;
    logic [31:0] e_scnt;
    logic [31:0] e_fcnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs1_v, id_rs2_v, id_rd_v, id_is_load, ex_redirect;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          stall_if, stall_id, bubble_ex, flush_id;
  logic [1:0]    fwd_sel1, fwd_sel2, state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int passes = 0;

  vec_t vecs[NV];

  int          hist_rd[3];
  bit          hist_ld[3];
  int          flush_left;
  bit          in_ld;
  int unsigned m_scnt, m_fcnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1_v    (id_rs1_v),
    .id_rs1      (id_rs1),
    .id_rs2_v    (id_rs2_v),
    .id_rs2      (id_rs2),
    .id_rd_v     (id_rd_v),
    .id_rd       (id_rd),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .bubble_ex   (bubble_ex),
    .flush_id    (flush_id),
    .fwd_sel1    (fwd_sel1),
    .fwd_sel2    (fwd_sel2),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  function automatic vec_t mk(input int valid, r1v, r1, r2v, r2, rdv, rd, ld, redir,
                              e_stall, e_flush, e_state, e_fwd1, e_fwd2, e_scnt, e_fcnt);
    vec_t v;
    v.valid = 1'(valid);  v.r1v = 1'(r1v);  v.r1 = 5'(r1);  v.r2v = 1'(r2v);
    v.r2 = 5'(r2);  v.rdv = 1'(rdv);  v.rd = 5'(rd);  v.ld = 1'(ld);
    v.redir = 1'(redir);  v.e_stall = 1'(e_stall);  v.e_flush = 1'(e_flush);
    v.e_state = 2'(e_state);  v.e_fwd1 = 2'(e_fwd1);  v.e_fwd2 = 2'(e_fwd2);
    v.e_scnt = 32'(e_scnt);  v.e_fcnt = 32'(e_fcnt);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t s);
    id_valid    = s.valid;
    id_rs1_v    = s.r1v;
    id_rs1      = s.r1;
    id_rs2_v    = s.r2v;
    id_rs2      = s.r2;
    id_rd_v     = s.rdv;
    id_rd       = s.rd;
    id_is_load  = s.ld;
    ex_redirect = s.redir;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Youngest in-flight writer of rs, skipping a load still in EX.
  function automatic logic [1:0] modelFwd(input logic rv, input int rs);
    if (!rv || rs == 0) return 2'd0;
    for (int age = 0; age < 3; age++) begin
      if (hist_rd[age] == rs) begin
        if (age == 0 && hist_ld[0]) continue;
        return 2'(age + 1);
      end
    end
    return 2'd0;
  endfunction

  initial begin
    vec_t s;
    logic lduse, e_stall, e_flush, e_bub;
    logic [1:0] e_state, e_f1, e_f2;

    // ADD x5 / ADD x6,x5,x1 / LW x5 / ADD x6,x5,x5 / x0 cases / redirect / LW+redirect
    vecs[0]  = mk(1,1,1,1,2,1,5,0,0,   0,0,0, 0,0, 0,0);
    vecs[1]  = mk(1,1,5,1,1,1,6,0,0,   0,0,0, 1,0, 0,0);
    vecs[2]  = mk(0,0,0,0,0,0,0,0,0,   0,0,0, 0,0, 0,0);
    vecs[3]  = mk(1,1,1,0,0,1,5,1,0,   0,0,0, 0,0, 0,0);
    vecs[4]  = mk(1,1,5,1,5,1,6,0,0,   1,0,0, 0,0, 1,0);
    vecs[5]  = mk(1,1,5,1,5,1,6,0,0,   0,0,1, 2,2, 1,0);
    vecs[6]  = mk(1,1,1,0,0,1,0,0,0,   0,0,0, 0,0, 1,0);
    vecs[7]  = mk(1,1,0,1,0,1,7,0,0,   0,0,0, 0,0, 1,0);
    vecs[8]  = mk(0,0,0,0,0,0,0,0,1,   0,1,0, 0,0, 1,1);
    vecs[9]  = mk(0,0,0,0,0,0,0,0,0,   0,1,2, 0,0, 1,1);
    vecs[10] = mk(0,0,0,0,0,0,0,0,0,   0,1,2, 0,0, 1,1);
    vecs[11] = mk(0,0,0,0,0,0,0,0,0,   0,0,0, 0,0, 1,1);
    vecs[12] = mk(1,0,0,0,0,1,9,1,0,   0,0,0, 0,0, 1,1);
    vecs[13] = mk(1,1,9,1,0,1,10,0,1,  0,1,0, 0,0, 1,2);
    vecs[14] = mk(0,0,0,0,0,0,0,0,0,   0,1,2, 0,0, 1,2);
    vecs[15] = mk(0,0,0,0,0,0,0,0,0,   0,1,2, 0,0, 1,2);
    vecs[16] = mk(0,0,0,0,0,0,0,0,0,   0,0,0, 0,0, 1,2);

    rst_n = 1'b0;
    applyStimulus(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    #1;
    checkOutput("rst_stall_if", 32'(stall_if), 0);
    checkOutput("rst_flush_id", 32'(flush_id), 0);
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_fwd1", 32'(fwd_sel1), 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    doReset();

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_stall_if", i), 32'(stall_if), 32'(vecs[i].e_stall));
      checkOutput($sformatf("vec%0d_stall_id", i), 32'(stall_id), 32'(vecs[i].e_stall));
      checkOutput($sformatf("vec%0d_flush_id", i), 32'(flush_id), 32'(vecs[i].e_flush));
      checkOutput($sformatf("vec%0d_bubble_ex", i), 32'(bubble_ex),
                  32'(vecs[i].e_stall | vecs[i].e_flush));
      checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_fwd1", i), 32'(fwd_sel1), 32'(vecs[i].e_fwd1));
      checkOutput($sformatf("vec%0d_fwd2", i), 32'(fwd_sel2), 32'(vecs[i].e_fwd2));
      checkOutput($sformatf("vec%0d_stall_cnt", i), stall_cnt, vecs[i].e_scnt);
      checkOutput($sformatf("vec%0d_flush_cnt", i), flush_cnt, vecs[i].e_fcnt);
    end

    // Reset asserted while sitting in the load-use stall state.
    @(negedge clk);
    applyStimulus(mk(1,0,0,0,0,1,5,1,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    applyStimulus(mk(1,1,5,0,0,1,6,0,0, 0,0,0,0,0,0,0));
    #1;
    checkOutput("seq_ldstall_stall_if", 32'(stall_if), 1);
    @(posedge clk);
    #1;
    checkOutput("seq_ldstall_state", 32'(state), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("seq_rst_stall_if", 32'(stall_if), 0);
    checkOutput("seq_rst_stall_id", 32'(stall_id), 0);
    checkOutput("seq_rst_bubble_ex", 32'(bubble_ex), 0);
    checkOutput("seq_rst_flush_id", 32'(flush_id), 0);
    checkOutput("seq_rst_fwd1", 32'(fwd_sel1), 0);
    checkOutput("seq_rst_fwd2", 32'(fwd_sel2), 0);
    checkOutput("seq_rst_state", 32'(state), 0);
    checkOutput("seq_rst_stall_cnt", stall_cnt, 0);
    checkOutput("seq_rst_flush_cnt", flush_cnt, 0);
    applyStimulus(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("seq_post_rst_state", 32'(state), 0);

    doReset();
    for (int k = 0; k < 3; k++) begin
      hist_rd[k] = 0;
      hist_ld[k] = 1'b0;
    end
    flush_left = 0;
    in_ld      = 1'b0;
    m_scnt     = 0;
    m_fcnt     = 0;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      s = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.r1v   = 1'($urandom_range(0, 1));
      s.r1    = 5'($urandom_range(0, 7));
      s.r2v   = 1'($urandom_range(0, 1));
      s.r2    = 5'($urandom_range(0, 7));
      s.rdv   = 1'($urandom_range(0, 1));
      s.rd    = 5'($urandom_range(0, 7));
      s.ld    = ($urandom_range(0, 9) < 3);
      s.redir = ($urandom_range(0, 11) == 0);
      applyStimulus(s);
      #1;
      lduse   = s.valid && hist_ld[0] &&
                ((s.r1v && s.r1 != 0 && hist_rd[0] == int'(s.r1)) ||
                 (s.r2v && s.r2 != 0 && hist_rd[0] == int'(s.r2)));
      e_stall = lduse && !s.redir && flush_left == 0;
      e_flush = s.redir || flush_left > 0;
      e_bub   = e_stall || e_flush;
      e_state = (flush_left > 0) ? 2'd2 : (in_ld ? 2'd1 : 2'd0);
      e_f1    = e_bub ? 2'd0 : modelFwd(s.r1v, int'(s.r1));
      e_f2    = e_bub ? 2'd0 : modelFwd(s.r2v, int'(s.r2));
      checkOutput("rnd_stall_if", 32'(stall_if), 32'(e_stall));
      checkOutput("rnd_stall_id", 32'(stall_id), 32'(e_stall));
      checkOutput("rnd_flush_id", 32'(flush_id), 32'(e_flush));
      checkOutput("rnd_bubble_ex", 32'(bubble_ex), 32'(e_bub));
      checkOutput("rnd_state", 32'(state), 32'(e_state));

      in_ld = (flush_left == 0) && !in_ld && !s.redir && lduse;
      if (s.redir) flush_left = FC;
      else if (flush_left > 0) flush_left--;
      hist_rd[2] = hist_rd[1];  hist_ld[2] = hist_ld[1];
      hist_rd[1] = hist_rd[0];  hist_ld[1] = hist_ld[0];
      if (s.valid && s.rdv && s.rd != 0 && !e_bub) begin
        hist_rd[0] = int'(s.rd);
        hist_ld[0] = s.ld;
      end else begin
        hist_rd[0] = 0;
        hist_ld[0] = 1'b0;
      end
      if (e_stall) m_scnt++;
      if (s.redir) m_fcnt++;

      @(posedge clk);
      #1;
      checkOutput("rnd_fwd1", 32'(fwd_sel1), 32'(e_f1));
      checkOutput("rnd_fwd2", 32'(fwd_sel2), 32'(e_f2));
      checkOutput("rnd_stall_cnt", stall_cnt, m_scnt);
      checkOutput("rnd_flush_cnt", flush_cnt, m_fcnt);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
